// File: rtl/zacore_mem_arbiter.sv
// Shares the single external memory port between instruction fetch and load/store,
// with a starvation guard for fetch and a fixed-latency tag pipeline steering read data.
module zacore_mem_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic [31:0] i_fetch_addr,
  output logic        o_fetch_rvalid,
  output logic [31:0] o_fetch_rdata,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_wmask,
  output logic        o_data_rvalid,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  input  logic        i_mem_gnt,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic {NORMAL, FORCE_FETCH} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                 state;
  logic [3:0]             starve_cnt;
  logic [MEM_LATENCY-1:0] tag_valid;
  logic [MEM_LATENCY-1:0] tag_fetch;

  logic sel_fetch;
  logic sel_data;
  logic fetch_acc;
  logic data_acc;
  logic fetch_lost;
  logic read_acc;

  always_comb begin
    sel_fetch  = i_fetch_valid & (~i_data_valid | (state == FORCE_FETCH));
    sel_data   = i_data_valid & ~sel_fetch;
    fetch_acc  = sel_fetch & i_mem_gnt;
    data_acc   = sel_data & i_mem_gnt;
    fetch_lost = i_fetch_valid & data_acc;
    read_acc   = fetch_acc | (data_acc & ~i_data_we);
  end

  assign o_fetch_ready = fetch_acc;
  assign o_data_ready  = data_acc;
  assign o_mem_req     = i_fetch_valid | i_data_valid;

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    if (sel_fetch) begin
      o_mem_addr = i_fetch_addr;
    end else if (sel_data) begin
      o_mem_we    = i_data_we;
      o_mem_addr  = i_data_addr;
      o_mem_wdata = i_data_wdata;
      o_mem_wmask = i_data_wmask;
    end
  end

  // Counter only ever climbs in NORMAL, where it stays below LIMIT, so +1 cannot wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (!i_fetch_valid || fetch_acc) begin
            starve_cnt <= '0;
          end else if (fetch_lost) begin
            if (starve_cnt + 4'd1 >= LIMIT) begin
              starve_cnt <= LIMIT;
              state      <= FORCE_FETCH;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        FORCE_FETCH: begin
          if (fetch_acc || !i_fetch_valid) begin
            starve_cnt <= '0;
            state      <= NORMAL;
          end
        end
        default: begin
          starve_cnt <= '0;
          state      <= NORMAL;
        end
      endcase
    end
  end

  // Shift form works for every legal latency, including a single stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_valid <= '0;
      tag_fetch <= '0;
    end else begin
      tag_valid <= (tag_valid << 1) | MEM_LATENCY'(read_acc);
      tag_fetch <= (tag_fetch << 1) | MEM_LATENCY'(fetch_acc);
    end
  end

  assign o_fetch_rvalid = tag_valid[MEM_LATENCY-1] & tag_fetch[MEM_LATENCY-1];
  assign o_data_rvalid  = tag_valid[MEM_LATENCY-1] & ~tag_fetch[MEM_LATENCY-1];
  assign o_fetch_rdata  = i_mem_rdata;
  assign o_data_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Scoreboard bench for zacore_mem_arbiter: memory returns a cycle-stamped word so
// both the latency and the steering of every read response are checked.
module tb_zacore_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_fetch_valid, o_fetch_ready, o_fetch_rvalid;
  logic [31:0] i_fetch_addr, o_fetch_rdata;
  logic        i_data_valid, o_data_ready, i_data_we, o_data_rvalid;
  logic [31:0] i_data_addr, i_data_wdata, o_data_rdata;
  logic [3:0]  i_data_wmask;
  logic        o_mem_req, o_mem_we, i_mem_gnt;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_wmask;

  zacore_mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready), .i_fetch_addr(i_fetch_addr),
    .o_fetch_rvalid(o_fetch_rvalid), .o_fetch_rdata(o_fetch_rdata),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data_we(i_data_we),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata), .i_data_wmask(i_data_wmask),
    .o_data_rvalid(o_data_rvalid), .o_data_rdata(o_data_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_gnt(i_mem_gnt), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [31:0] cyc32;
  assign cyc32       = cyc;
  assign i_mem_rdata = {16'hC0DE, cyc32[15:0]};

  typedef struct {
    logic        is_fetch;
    logic [31:0] due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_fetch_rvalid || o_data_rvalid) begin
      check("rvalid_onehot", 32'(o_fetch_rvalid & o_data_rvalid), 32'd0);
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {30'd0, o_fetch_rvalid, o_data_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_is_fetch", 32'(o_fetch_rvalid), 32'(e.is_fetch));
        check("rsp_cycle", cyc32, e.due);
        check("rsp_rdata", o_fetch_rvalid ? o_fetch_rdata : o_data_rdata,
              {16'hC0DE, e.due[15:0]});
      end
    end
  end

  task automatic drive(input logic fv, input logic [31:0] fa, input logic dv, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dwm,
                       input logic gnt);
    @(posedge i_clk);
    #1;
    i_fetch_valid = fv;
    i_fetch_addr  = fa;
    i_data_valid  = dv;
    i_data_we     = dwe;
    i_data_addr   = da;
    i_data_wdata  = dwd;
    i_data_wmask  = dwm;
    i_mem_gnt     = gnt;
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      check("idle_req", 32'(o_mem_req), 32'd0);
      check("idle_addr", o_mem_addr, 32'd0);
    end
  endtask

  task automatic read_step(input logic fv, input logic [31:0] fa, input logic dv,
                           input logic [31:0] da, input logic exp_f, input string tag);
    exp_t x;
    drive(fv, fa, dv, 1'b0, da, '0, '0, 1'b1);
    check({tag, "_fready"}, 32'(o_fetch_ready), 32'(exp_f));
    check({tag, "_dready"}, 32'(o_data_ready), 32'(!exp_f));
    check({tag, "_addr"}, o_mem_addr, exp_f ? fa : da);
    check({tag, "_we"}, 32'(o_mem_we), 32'd0);
    x.is_fetch = exp_f;
    x.due      = cyc32 + LAT;
    sb.push_back(x);
  endtask

  logic        pat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] fa, da;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1;
    i_fetch_valid = 1'b0; i_fetch_addr = '0; i_data_valid = 1'b0; i_data_we = 1'b0;
    i_data_addr = '0; i_data_wdata = '0; i_data_wmask = '0; i_mem_gnt = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #4;
    check("rst_fetch_rvalid", 32'(o_fetch_rvalid), 32'd0);
    check("rst_data_rvalid", 32'(o_data_rvalid), 32'd0);
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;

    // 1: fetch-only read
    read_step(1'b1, 32'h100, 1'b0, '0, 1'b1, "t1");
    check("t1_wdata", o_mem_wdata, 32'd0);
    check("t1_wmask", 32'(o_mem_wmask), 32'd0);
    idle(3);

    // 2: sustained tie, starvation forces one fetch grant
    fa = 32'h200; da = 32'h300;
    for (int i = 0; i < 6; i++) begin
      read_step(1'b1, fa, 1'b1, da, pat[i], "t2");
      if (pat[i]) fa += 4; else da += 4;
    end
    idle(3);

    // 3: store stalled by gnt, fields held stable
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0101, i == 2);
      check("t3_dready", 32'(o_data_ready), 32'(i == 2));
      check("t3_fready", 32'(o_fetch_ready), 32'd0);
      check("t3_req", 32'(o_mem_req), 32'd1);
      check("t3_we", 32'(o_mem_we), 32'd1);
      check("t3_addr", o_mem_addr, 32'h20);
      check("t3_wdata", o_mem_wdata, 32'hDEADBEEF);
      check("t3_wmask", 32'(o_mem_wmask), 32'b0101);
    end
    idle(3);

    // 4: back-to-back alternating loads
    for (int i = 0; i < 5; i++) begin
      read_step((i % 2) == 0, 32'h400 + 32'(i * 4), (i % 2) == 1, 32'h500 + 32'(i * 4),
                (i % 2) == 0, "t4");
    end
    idle(3);

    // 5: reset with two reads in flight
    read_step(1'b1, 32'h600, 1'b0, '0, 1'b1, "t5");
    read_step(1'b0, '0, 1'b1, 32'h700, 1'b0, "t5");
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    sb.delete();
    i_fetch_valid = 1'b1; i_fetch_addr = 32'h800; i_data_valid = 1'b0; i_mem_gnt = 1'b0;
    #3;
    check("t5_rst_fetch_rvalid", 32'(o_fetch_rvalid), 32'd0);
    check("t5_rst_data_rvalid", 32'(o_data_rvalid), 32'd0);
    check("t5_rst_comb_addr", o_mem_addr, 32'h800);
    @(posedge i_clk); #4;
    check("t5_rst2_rvalid", {30'd0, o_fetch_rvalid, o_data_rvalid}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_fetch_valid = 1'b0;
    read_step(1'b0, '0, 1'b1, 32'h900, 1'b0, "t5post");
    idle(3);

    // 6: reach FORCE_FETCH, then fetch withdraws before its grant
    for (int i = 0; i < 3; i++)
      read_step(1'b1, 32'hA00, 1'b1, 32'hB00 + 32'(i * 4), 1'b0, "t6");
    drive(1'b1, 32'hA00, 1'b1, 1'b0, 32'hB0C, '0, '0, 1'b0);
    check("t6_force_sel", o_mem_addr, 32'hA00);
    check("t6_force_noacc", {30'd0, o_fetch_ready, o_data_ready}, 32'd0);
    read_step(1'b0, '0, 1'b1, 32'hB0C, 1'b0, "t6drop");
    read_step(1'b1, 32'hA00, 1'b1, 32'hB10, 1'b0, "t6tie");
    idle(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
